m2_wra: RTL and testbench
=========================

# m2_wra

AHB-Lite master wrapper for the CPU data-memory port (master M2, `HMASTER` = 4'b0001). It converts one CPU load/store request into a single AHB transfer on the shared bus: request arbitration, address phase, then data phase. The transfer normally targets the DM slave wrapper (S2). The CPU is stalled until the transfer completes.

## Interface
Parameters:
- `RETRY_MAX`, 3, retries after an ERROR response (used only when `M2_ERR_RETRY_EN` is defined)

Ports:
- `clk` in 1: single clock; all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `cpu_req` in 1: CPU data access request; held stable until `cpu_stall` is 0
- `cpu_write` in 1: 1 = store, 0 = load
- `cpu_addr` in `AHB_DATA_BITS`: byte address
- `cpu_wdata` in `AHB_DATA_BITS`: store data
- `cpu_size` in `AHB_SIZE_BITS`: access size, passed to `HSIZE`
- `cpu_rdata` out `AHB_DATA_BITS`: load data; valid in DONE
- `cpu_stall` out 1: CPU freeze
- `cpu_err` out 1: error flag, valid in DONE
- `HGRANT_M2` in 1: arbiter grant
- `HREADY` in 1: bus ready
- `HRESP` in `AHB_RESP_BITS`: slave response
- `HRDATA` in `AHB_DATA_BITS`: read data
- `HBUSREQ_M2` out 1: bus request
- `HLOCK_M2` out 1: tied 0
- `HTRANS_M2` out `AHB_TRANS_BITS`: IDLE = 2'b00, NONSEQ = 2'b10
- `HADDR_M2` out `AHB_DATA_BITS`: transfer address
- `HWRITE_M2` out 1: transfer direction
- `HSIZE_M2` out `AHB_SIZE_BITS`: transfer size
- `HWDATA_M2` out `AHB_DATA_BITS`: write data

## Operation
- Request latch: on IDLE with `cpu_req` = 1, register `cpu_addr`, `cpu_write`, `cpu_wdata` and `cpu_size`. All AHB outputs are driven from these latched copies.
- FSM states: IDLE, REQ, ADDR, DATA, DONE.
  - IDLE: `cpu_req` = 1 → REQ; otherwise stay in IDLE.
  - REQ: `HBUSREQ_M2` = 1. `HGRANT_M2` && `HREADY` → ADDR; otherwise hold.
  - ADDR: `HTRANS_M2` = NONSEQ; `HADDR_M2`, `HWRITE_M2` and `HSIZE_M2` driven; `HBUSREQ_M2` = 1. `HREADY` = 1 → DATA; otherwise hold with outputs unchanged.
  - DATA: `HTRANS_M2` = IDLE, `HBUSREQ_M2` = 0, `HWDATA_M2` = latched wdata. On `HREADY` = 1:
    - OKAY response → DONE. If read, capture `HRDATA` into `cpu_rdata`.
    - ERROR response → handled as in Configuration.
  - DONE: `cpu_stall` = 0 for exactly one cycle, then → IDLE.
- `cpu_stall` is combinational: 1 when (IDLE && `cpu_req`) or state ∈ {REQ, ADDR, DATA}; 0 in DONE and in IDLE without a request.
- `cpu_rdata` holds its value until the next captured read. Writes leave it unchanged.
- `cpu_err` is 1 only in DONE, and only for an errored transfer. An errored read returns `cpu_rdata` = 0.
- Reset values: state IDLE, `HTRANS_M2` = IDLE, `HBUSREQ_M2` = 0, `HLOCK_M2` = 0, all address/data outputs 0, `cpu_rdata` = 0, `cpu_err` = 0, retry count 0.

## Timing
- Minimum latency with grant held and zero-wait slave: request seen at cycle 0 (IDLE), REQ at 1, ADDR at 2, DATA at 3, DONE at 4.
- Each slave wait state (`HREADY` = 0) adds one cycle in ADDR or DATA.
- Grant lost while in REQ: stay in REQ, keep the request asserted.
- `rst` asserted mid-transfer: IDLE on the next edge with reset values. The in-flight transfer is abandoned with no completion pulse.
- `cpu_req` asserted in DONE is ignored. It is taken on the following IDLE cycle, so back-to-back accesses are spaced 5 cycles apart.

## Configuration
- `M2_ERR_RETRY_EN` defined: on ERROR, if retry count < `RETRY_MAX`, increment the count and go to REQ, reissuing the identical transfer. Otherwise go to DONE with `cpu_err` = 1. The count clears in DONE.
- `M2_ERR_RETRY_EN` undefined: on ERROR, go directly to DONE with `cpu_err` = 1. No retry counter is synthesized.

## Structure
- Shared package (`AHB_def` scope) holds:
  - the FSM state enum;
  - HTRANS encodings IDLE and NONSEQ;
  - HRESP encodings OKAY = 2'b00 and ERROR = 2'b01;
  - the M2 master ID constant 4'b0001.
- Single module; no sub-module.

## Test plan
- Load, grant always high, zero-wait slave, `HRDATA` = 32'hDEAD_BEEF, `cpu_addr` = 32'h0000_0010 → `HADDR_M2` = 32'h10 with NONSEQ in cycle 2; `cpu_stall` low and `cpu_rdata` = 32'hDEAD_BEEF in cycle 4.
- Store with `cpu_wdata` = 32'h1234_5678 against an S2-style slave (one wait state) → `HWDATA_M2` = 32'h1234_5678 for the whole DATA phase; DONE in cycle 5.
- Grant withheld for 3 cycles → `HBUSREQ_M2` held high; ADDR entered the cycle after grant; latency = 4 + 3.
- ERROR response on a read, retry compiled out → DONE with `cpu_err` = 1 and `cpu_rdata` = 0. Same stimulus with `M2_ERR_RETRY_EN` and a permanent error → 4 transfers issued, then `cpu_err` = 1.
- `rst` pulsed while in DATA → next cycle: state IDLE, `HTRANS_M2` = 2'b00, `HBUSREQ_M2` = 0, `cpu_stall` = 0 (with `cpu_req` low).
- Back-to-back loads with `cpu_req` held → two NONSEQ transfers 5 cycles apart; second `cpu_rdata` matches second `HRDATA`.

Source files
------------

// File: rtl/m2_wra_pkg.sv
// -----------------------------------------------------------------------------
// AHB_def : shared AHB-Lite definitions for the M2 (CPU data port) master.
//
// Contents:
//   - bus field widths (data/address, size, response, transfer type)
//   - HTRANS encodings (IDLE, NONSEQ) and HRESP encodings (OKAY, ERROR)
//   - master ID of M2 as seen on HMASTER
//   - the m2_wra state enumeration
// -----------------------------------------------------------------------------
package AHB_def;

  localparam int AHB_DATA_BITS  = 32;
  localparam int AHB_SIZE_BITS  = 3;
  localparam int AHB_RESP_BITS  = 2;
  localparam int AHB_TRANS_BITS = 2;

  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [AHB_TRANS_BITS-1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [AHB_RESP_BITS-1:0]  HRESP_OKAY    = 2'b00;
  localparam logic [AHB_RESP_BITS-1:0]  HRESP_ERROR   = 2'b01;

  localparam logic [3:0]                HMASTER_M2    = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } m2_state_e;

endpackage

// File: rtl/m2_wra.sv
// -----------------------------------------------------------------------------
// m2_wra : AHB-Lite master wrapper for the CPU data-memory port (master M2).
//
// Turns one CPU load/store into a single AHB transfer: bus request, address
// phase, data phase, then a one-cycle DONE that releases the CPU stall.
//
// Parameters:
//   RETRY_MAX  retries after an ERROR response (only with M2_ERR_RETRY_EN)
//
// Build option:
//   M2_ERR_RETRY_EN  defined   -> ERROR responses reissue the transfer up to
//                                 RETRY_MAX times before reporting cpu_err
//                    undefined -> ERROR goes straight to DONE with cpu_err
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_req/write/addr/
//   cpu_wdata/size           CPU request, held until cpu_stall is 0
//   cpu_rdata, cpu_err       load data / error flag, valid in DONE
//   cpu_stall                CPU freeze (combinational)
//   HGRANT_M2, HREADY,
//   HRESP, HRDATA            AHB inputs from arbiter / selected slave
//   HBUSREQ_M2, HLOCK_M2,
//   HTRANS_M2, HADDR_M2,
//   HWRITE_M2, HSIZE_M2,
//   HWDATA_M2                AHB master outputs
// -----------------------------------------------------------------------------
module m2_wra
  import AHB_def::*;
#(
  parameter int RETRY_MAX = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req,
  input  logic                      cpu_write,
  input  logic [AHB_DATA_BITS-1:0]  cpu_addr,
  input  logic [AHB_DATA_BITS-1:0]  cpu_wdata,
  input  logic [AHB_SIZE_BITS-1:0]  cpu_size,
  output logic [AHB_DATA_BITS-1:0]  cpu_rdata,
  output logic                      cpu_stall,
  output logic                      cpu_err,
  input  logic                      HGRANT_M2,
  input  logic                      HREADY,
  input  logic [AHB_RESP_BITS-1:0]  HRESP,
  input  logic [AHB_DATA_BITS-1:0]  HRDATA,
  output logic                      HBUSREQ_M2,
  output logic                      HLOCK_M2,
  output logic [AHB_TRANS_BITS-1:0] HTRANS_M2,
  output logic [AHB_DATA_BITS-1:0]  HADDR_M2,
  output logic                      HWRITE_M2,
  output logic [AHB_SIZE_BITS-1:0]  HSIZE_M2,
  output logic [AHB_DATA_BITS-1:0]  HWDATA_M2
);

  // Reject nonsensical retry limits at elaboration time.
  if (RETRY_MAX < 0 || RETRY_MAX > 255) begin : g_bad_retry_max
    $error("m2_wra: RETRY_MAX out of range");
  end

  m2_state_e state, next_state;

  logic [AHB_DATA_BITS-1:0] addr_q;
  logic [AHB_DATA_BITS-1:0] wdata_q;
  logic [AHB_SIZE_BITS-1:0] size_q;
  logic                     write_q;
  logic [AHB_DATA_BITS-1:0] rdata_q;
  logic                     err_q;

  logic take_req;    // latch the CPU request this cycle
  logic rd_capture;  // successful read completes this cycle
  logic err_done;    // errored transfer completes this cycle

`ifdef M2_ERR_RETRY_EN
  localparam int CNT_BITS = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  logic [CNT_BITS-1:0] retry_cnt;
  logic                retry;
`endif

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    take_req   = 1'b0;
    rd_capture = 1'b0;
    err_done   = 1'b0;
`ifdef M2_ERR_RETRY_EN
    retry      = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          next_state = ST_REQ;
          take_req   = 1'b1;
        end
      end
      ST_REQ: begin
        if (HGRANT_M2 && HREADY) next_state = ST_ADDR;
      end
      ST_ADDR: begin
        if (HREADY) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (HREADY) begin
          if (HRESP == HRESP_ERROR) begin
`ifdef M2_ERR_RETRY_EN
            if (retry_cnt < CNT_BITS'(RETRY_MAX)) begin
              retry      = 1'b1;
              next_state = ST_REQ;   // reissue from the latched copies
            end else begin
              err_done   = 1'b1;
              next_state = ST_DONE;
            end
`else
            err_done   = 1'b1;
            next_state = ST_DONE;
`endif
          end else begin
            // Any non-ERROR response completes the transfer.
            rd_capture = !write_q;
            next_state = ST_DONE;
          end
        end
      end
      ST_DONE: next_state = ST_IDLE;   // a request seen here waits for IDLE
      default: next_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (take_req) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        size_q  <= cpu_size;
        write_q <= cpu_write;
      end
      if (rd_capture)              rdata_q <= HRDATA;
      else if (err_done && !write_q) rdata_q <= '0;
      // Set on the edge into DONE, cleared on the edge leaving it.
      err_q <= err_done;
    end
  end

`ifdef M2_ERR_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst)                   retry_cnt <= '0;
    else if (state == ST_DONE) retry_cnt <= '0;
    else if (retry)            retry_cnt <= retry_cnt + CNT_BITS'(1);
  end
`endif

  // AHB outputs come from the latched request, never from live CPU inputs.
  assign HTRANS_M2  = (state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HBUSREQ_M2 = (state == ST_REQ) || (state == ST_ADDR);
  assign HLOCK_M2   = 1'b0;
  assign HADDR_M2   = addr_q;
  assign HWRITE_M2  = write_q;
  assign HSIZE_M2   = size_q;
  assign HWDATA_M2  = wdata_q;

  assign cpu_stall = ((state == ST_IDLE) && cpu_req) ||
                     (state == ST_REQ) || (state == ST_ADDR) || (state == ST_DATA);
  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

endmodule

// File: tb/tb_m2_wra.sv
// -----------------------------------------------------------------------------
// tb_m2_wra : self-checking bench for m2_wra.
//
// A behavioural arbiter/slave answers each access; expected bus transfers and
// CPU completions are queued when a request is driven and compared when the
// DUT issues NONSEQ or releases cpu_stall.
// -----------------------------------------------------------------------------
module tb_m2_wra;
  import AHB_def::*;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      cpu_req;
  logic                      cpu_write;
  logic [AHB_DATA_BITS-1:0]  cpu_addr;
  logic [AHB_DATA_BITS-1:0]  cpu_wdata;
  logic [AHB_SIZE_BITS-1:0]  cpu_size;
  logic [AHB_DATA_BITS-1:0]  cpu_rdata;
  logic                      cpu_stall;
  logic                      cpu_err;
  logic                      HGRANT_M2;
  logic                      HREADY;
  logic [AHB_RESP_BITS-1:0]  HRESP;
  logic [AHB_DATA_BITS-1:0]  HRDATA;
  logic                      HBUSREQ_M2;
  logic                      HLOCK_M2;
  logic [AHB_TRANS_BITS-1:0] HTRANS_M2;
  logic [AHB_DATA_BITS-1:0]  HADDR_M2;
  logic                      HWRITE_M2;
  logic [AHB_SIZE_BITS-1:0]  HSIZE_M2;
  logic [AHB_DATA_BITS-1:0]  HWDATA_M2;

  m2_wra dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_size   (cpu_size),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .cpu_err    (cpu_err),
    .HGRANT_M2  (HGRANT_M2),
    .HREADY     (HREADY),
    .HRESP      (HRESP),
    .HRDATA     (HRDATA),
    .HBUSREQ_M2 (HBUSREQ_M2),
    .HLOCK_M2   (HLOCK_M2),
    .HTRANS_M2  (HTRANS_M2),
    .HADDR_M2   (HADDR_M2),
    .HWRITE_M2  (HWRITE_M2),
    .HSIZE_M2   (HSIZE_M2),
    .HWDATA_M2  (HWDATA_M2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  xfer_t       exp_q[$];
  resp_t       resp_q[$];
  logic [31:0] model_rdata = 32'h0;

  // Drives one CPU access from cycle 0 (caller sits on a negedge) and plays
  // arbiter + slave. Grant is withheld for gnt_delay REQ cycles; each data
  // phase inserts data_wait wait states; err_rsp makes every data phase ERROR.
  task automatic run_access(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input int gnt_delay,
                            input int data_wait, input logic err_rsp,
                            input logic [31:0] rdata, input logic keep_req,
                            output int lat, output int nxfer,
                            output int first_ns, output int ns_abs);
    xfer_t x;
    resp_t r;
    bit    dp;
    bit    done;
    int    wcnt;
    x.addr = addr; x.wr = wr; x.size = 3'b010; x.wdata = wdata;
    exp_q.push_back(x);
    if (wr) r.rdata = model_rdata;
    else    r.rdata = err_rsp ? 32'h0 : rdata;
    r.err = err_rsp;
    model_rdata = r.rdata;
    resp_q.push_back(r);
    lat = -1; nxfer = 0; first_ns = -1; ns_abs = -1;
    dp = 1'b0; done = 1'b0; wcnt = 0;
    cpu_req = 1'b1; cpu_write = wr; cpu_addr = addr;
    cpu_wdata = wdata; cpu_size = 3'b010;
    for (int c = 0; c < 200 && !done; c++) begin
      HGRANT_M2 = (c > gnt_delay);
      if (dp) begin
        HREADY = (wcnt >= data_wait);
        HRESP  = (HREADY && err_rsp) ? HRESP_ERROR : HRESP_OKAY;
        HRDATA = HREADY ? rdata : 32'h0BAD_0BAD;
      end else begin
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        HRDATA = 32'h0;
      end
      #1;
      if (c > 0 && !cpu_stall) begin
        done = 1'b1;
        lat  = c;
        r = resp_q.pop_front();
        x = exp_q.pop_front();
        tests_run++;
        if (cpu_rdata !== r.rdata) begin
          tests_failed++;
          $display("FAIL done_rdata: got %h expected %h", cpu_rdata, r.rdata);
        end
        tests_run++;
        if (cpu_err !== r.err) begin
          tests_failed++;
          $display("FAIL done_err: got %b expected %b", cpu_err, r.err);
        end
        cpu_req = keep_req;
      end else begin
        if (HTRANS_M2 === HTRANS_NONSEQ) begin
          tests_run++;
          if ({HADDR_M2, HWRITE_M2, HSIZE_M2} !== {x.addr, x.wr, x.size}) begin
            tests_failed++;
            $display("FAIL nonseq_fields: got %h/%b/%h expected %h/%b/%h",
                     HADDR_M2, HWRITE_M2, HSIZE_M2, x.addr, x.wr, x.size);
          end
          if (first_ns < 0) begin
            first_ns = c;
            ns_abs   = cyc;
          end
          if (HREADY) nxfer++;
        end
        if (c >= 1 && c <= gnt_delay) begin
          tests_run++;
          if (HBUSREQ_M2 !== 1'b1 || HTRANS_M2 !== HTRANS_IDLE) begin
            tests_failed++;
            $display("FAIL req_hold: got busreq=%b trans=%b expected 1/00",
                     HBUSREQ_M2, HTRANS_M2);
          end
        end
        if (dp) begin
          tests_run++;
          if (HTRANS_M2 !== HTRANS_IDLE || HBUSREQ_M2 !== 1'b0 ||
              (wr && HWDATA_M2 !== wdata)) begin
            tests_failed++;
            $display("FAIL data_phase: got trans=%b busreq=%b wdata=%h expected 00/0/%h",
                     HTRANS_M2, HBUSREQ_M2, HWDATA_M2, wdata);
          end
        end
        if (dp) begin
          if (HREADY) begin dp = 1'b0; wcnt = 0; end
          else wcnt++;
        end else if (HTRANS_M2 === HTRANS_NONSEQ && HREADY) begin
          dp = 1'b1;
        end
      end
      @(negedge clk);
    end
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL access_timeout: got no completion expected cpu_stall low");
      if (exp_q.size() > 0)  x = exp_q.pop_front();
      if (resp_q.size() > 0) r = resp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if ({HTRANS_M2, HBUSREQ_M2, HLOCK_M2, HWRITE_M2, HSIZE_M2} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {HTRANS_M2, HBUSREQ_M2, HLOCK_M2, HWRITE_M2, HSIZE_M2});
    end
    tests_run++;
    if ({HADDR_M2, HWDATA_M2, cpu_rdata} !== 96'h0) begin
      tests_failed++;
      $display("FAIL reset_data: got %h/%h/%h expected 0", HADDR_M2, HWDATA_M2, cpu_rdata);
    end
    tests_run++;
    if ({cpu_err, cpu_stall} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_cpu: got err=%b stall=%b expected 0/0", cpu_err, cpu_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int lat, n, fns, nsa;
    run_access(1'b0, 32'h0000_0010, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0,
               lat, n, fns, nsa);
    tests_run++;
    if (fns !== 2) begin
      tests_failed++;
      $display("FAIL load_nonseq_cycle: got %0d expected 2", fns);
    end
    tests_run++;
    if (lat !== 4 || n !== 1) begin
      tests_failed++;
      $display("FAIL load_latency: got %0d/%0d expected 4/1", lat, n);
    end
  endtask

  task automatic test_store_wait();
    int lat, n, fns, nsa;
    run_access(1'b1, 32'h0000_0020, 32'h1234_5678, 0, 1, 1'b0, 32'h5555_AAAA, 1'b0,
               lat, n, fns, nsa);
    tests_run++;
    if (lat !== 5 || n !== 1) begin
      tests_failed++;
      $display("FAIL store_latency: got %0d/%0d expected 5/1", lat, n);
    end
  endtask

  task automatic test_grant_delay();
    int lat, n, fns, nsa;
    run_access(1'b0, 32'h0000_0100, 32'h0, 3, 0, 1'b0, 32'hA5A5_5A5A, 1'b0,
               lat, n, fns, nsa);
    tests_run++;
    if (fns !== 5) begin
      tests_failed++;
      $display("FAIL grant_addr_cycle: got %0d expected 5", fns);
    end
    tests_run++;
    if (lat !== 7) begin
      tests_failed++;
      $display("FAIL grant_latency: got %0d expected 7", lat);
    end
  endtask

  task automatic test_error();
    int lat, n, fns, nsa;
    int exp_n, exp_lat;
`ifdef M2_ERR_RETRY_EN
    exp_n = 4; exp_lat = 13;
`else
    exp_n = 1; exp_lat = 4;
`endif
    run_access(1'b0, 32'h0000_0200, 32'h0, 0, 0, 1'b1, 32'hFFFF_0000, 1'b0,
               lat, n, fns, nsa);
    tests_run++;
    if (n !== exp_n) begin
      tests_failed++;
      $display("FAIL error_transfers: got %0d expected %0d", n, exp_n);
    end
    tests_run++;
    if (lat !== exp_lat) begin
      tests_failed++;
      $display("FAIL error_latency: got %0d expected %0d", lat, exp_lat);
    end
    // After the error, a clean read must complete with no error flag.
    run_access(1'b0, 32'h0000_0204, 32'h0, 0, 0, 1'b0, 32'h0F0F_F0F0, 1'b0,
               lat, n, fns, nsa);
  endtask

  task automatic test_rst_mid();
    HGRANT_M2 = 1'b1; HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = 32'h7777_7777;
    cpu_req = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h0000_0040; cpu_size = 3'b010;
    repeat (3) @(negedge clk);
    #1;
    tests_run++;
    if (HTRANS_M2 !== HTRANS_IDLE || HBUSREQ_M2 !== 1'b0 || cpu_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_mid_in_data: got trans=%b busreq=%b stall=%b expected 00/0/1",
               HTRANS_M2, HBUSREQ_M2, cpu_stall);
    end
    HREADY = 1'b0; rst = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (HTRANS_M2 !== HTRANS_IDLE || HBUSREQ_M2 !== 1'b0 || cpu_stall !== 1'b0 ||
        HADDR_M2 !== 32'h0 || cpu_rdata !== 32'h0 || cpu_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got trans=%b busreq=%b stall=%b addr=%h rdata=%h err=%b expected idle/reset values",
               HTRANS_M2, HBUSREQ_M2, cpu_stall, HADDR_M2, cpu_rdata, cpu_err);
    end
    model_rdata = 32'h0;
    rst = 1'b0; HREADY = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat1, n1, f1, a1, lat2, n2, f2, a2;
    run_access(1'b0, 32'h0000_0300, 32'h0, 0, 0, 1'b0, 32'h1111_2222, 1'b1,
               lat1, n1, f1, a1);
    run_access(1'b0, 32'h0000_0304, 32'h0, 0, 0, 1'b0, 32'hCAFE_F00D, 1'b0,
               lat2, n2, f2, a2);
    tests_run++;
    if (a2 - a1 !== 5) begin
      tests_failed++;
      $display("FAIL b2b_spacing: got %0d expected 5", a2 - a1);
    end
    tests_run++;
    if (lat2 !== 4) begin
      tests_failed++;
      $display("FAIL b2b_latency: got %0d expected 4", lat2);
    end
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_write = 1'b0; cpu_addr = '0;
    cpu_wdata = '0; cpu_size = '0; HGRANT_M2 = 1'b0; HREADY = 1'b1;
    HRESP = HRESP_OKAY; HRDATA = '0;
    @(negedge clk);
    test_reset();
    test_load();
    test_store_wait();
    test_grant_delay();
    test_error();
    test_rst_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of run expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
